// File: rtl/pipe_cmd_responder.sv
// rtl/pipe_cmd_responder.sv - Target-side host command responder driving a single-outstanding register bus.
// Commands are executed beat by beat; reads answer per beat, writes answer once at the end or on error.
module pipe_cmd_responder #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int RST_CYCLES     = 16,
  parameter int MAX_LEN        = 64
) (
  input  logic        user_clk,
  input  logic        user_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_type,
  input  logic [31:0] cmd_address,
  input  logic [31:0] cmd_data,
  input  logic [15:0] cmd_length,
  input  logic [7:0]  cmd_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_type,
  output logic [31:0] rsp_read_data,
  output logic [7:0]  rsp_tag,
  output logic [7:0]  rsp_status,
  output logic [31:0] rsp_timestamp,
  output logic        reg_req,
  output logic        reg_we,
  output logic [31:0] reg_addr,
  output logic [31:0] reg_wdata,
  input  logic        reg_ack,
  input  logic        reg_err,
  input  logic [31:0] reg_rdata,
  output logic        soft_rst,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_BUS, S_RSP, S_SRST} state_e;

  localparam logic [7:0] T_RD = 8'h01;
  localparam logic [7:0] T_WR = 8'h02;
  localparam logic [7:0] T_SR = 8'h03;
  localparam logic [7:0] ST_OK = 8'h00, ST_BUSERR = 8'h01, ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BADTYPE = 8'h03, ST_BADLEN = 8'h04;

  state_e      state_q, state_d;
  logic [7:0]  type_q, type_d, tag_q, tag_d, status_q, status_d, rsp_type_q, rsp_type_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic [31:0] ts_q, ts_d, rsp_ts_q, rsp_ts_d;
  logic [15:0] len_q, len_d, beat_q, beat_d, wait_q, wait_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic        req_q, req_d, srst_q, srst_d, ready_q, ready_d;

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    tag_d      = tag_q;
    status_d   = status_q;
    rsp_type_d = rsp_type_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    rsp_ts_d   = rsp_ts_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    rst_cnt_d  = rst_cnt_q;
    req_d      = req_q;
    srst_d     = srst_q;
    ts_d       = ts_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          type_d   = cmd_type;
          addr_d   = cmd_address;
          data_d   = cmd_data;
          tag_d    = cmd_tag;
          len_d    = (cmd_length == 16'd0) ? 16'd1 : cmd_length;
          beat_d   = 16'd0;
          rdata_d  = 32'd0;
          status_d = ST_OK;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (type_q != T_RD && type_q != T_WR && type_q != T_SR) begin
          status_d = ST_BADTYPE;
          state_d  = S_RSP;
        end else if (type_q == T_SR) begin
          srst_d    = 1'b1;
          rst_cnt_d = 8'd0;
          state_d   = S_SRST;
        end else if (len_q > 16'(MAX_LEN)) begin
          status_d = ST_BADLEN;
          state_d  = S_RSP;
        end else begin
          req_d   = 1'b1;
          wait_d  = 16'd0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (!req_q) begin
          // Inter-beat gap cycle for write bursts.
          req_d  = 1'b1;
          wait_d = 16'd0;
        end else if (reg_ack) begin
          req_d = 1'b0;
          if (type_q == T_RD) begin
            rdata_d = reg_rdata;
          end
          if (reg_err) begin
            status_d = ST_BUSERR;
            state_d  = S_RSP;
          end else if (type_q == T_RD || beat_q == len_q - 16'd1) begin
            status_d = ST_OK;
            state_d  = S_RSP;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end else if (wait_q == 16'(TIMEOUT_CYCLES - 1)) begin
          req_d    = 1'b0;
          status_d = ST_TIMEOUT;
          state_d  = S_RSP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          if (type_q == T_RD && status_q == ST_OK && beat_q != len_q - 16'd1) begin
            beat_d  = beat_q + 16'd1;
            req_d   = 1'b1;
            wait_d  = 16'd0;
            state_d = S_BUS;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_SRST: begin
        if (rst_cnt_q == 8'(RST_CYCLES - 1)) begin
          srst_d   = 1'b0;
          status_d = ST_OK;
          state_d  = S_RSP;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    // Response fields freeze on the cycle the response is first presented.
    if (state_d == S_RSP && state_q != S_RSP) begin
      rsp_ts_d   = ts_d;
      rsp_type_d = type_q | 8'h80;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q    <= S_IDLE;
      type_q     <= 8'd0;
      tag_q      <= 8'd0;
      status_q   <= 8'd0;
      rsp_type_q <= 8'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      rdata_q    <= 32'd0;
      ts_q       <= 32'd0;
      rsp_ts_q   <= 32'd0;
      len_q      <= 16'd0;
      beat_q     <= 16'd0;
      wait_q     <= 16'd0;
      rst_cnt_q  <= 8'd0;
      req_q      <= 1'b0;
      srst_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      tag_q      <= tag_d;
      status_q   <= status_d;
      rsp_type_q <= rsp_type_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      ts_q       <= ts_d;
      rsp_ts_q   <= rsp_ts_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      rst_cnt_q  <= rst_cnt_d;
      req_q      <= req_d;
      srst_q     <= srst_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready     = ready_q;
  assign rsp_valid     = (state_q == S_RSP);
  assign rsp_type      = rsp_type_q;
  assign rsp_read_data = rdata_q;
  assign rsp_tag       = tag_q;
  assign rsp_status    = status_q;
  assign rsp_timestamp = rsp_ts_q;
  assign reg_req       = req_q;
  assign reg_we        = (type_q == T_WR);
  assign reg_addr      = addr_q + {14'd0, beat_q, 2'b00};
  assign reg_wdata     = data_q;
  assign soft_rst      = srst_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pipe_cmd_responder.sv
// tb/tb_pipe_cmd_responder.sv - Directed self-checking bench for pipe_cmd_responder.
module tb_pipe_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_type = 8'd0, cmd_tag = 8'd0;
  logic [31:0] cmd_address = 32'd0, cmd_data = 32'd0;
  logic [15:0] cmd_length = 16'd0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [7:0]  rsp_type, rsp_tag, rsp_status;
  logic [31:0] rsp_read_data, rsp_timestamp;
  logic        reg_req, reg_we, reg_ack = 1'b0, reg_err = 1'b0;
  logic [31:0] reg_addr, reg_wdata, reg_rdata = 32'd0;
  logic        soft_rst, busy;

  int          n_cmp = 0, n_bad = 0, n_req = 0;
  logic        req_prev = 1'b0;
  logic [31:0] cyc = 32'd0;

  pipe_cmd_responder #(.TIMEOUT_CYCLES(8), .RST_CYCLES(16), .MAX_LEN(64)) dut (
    .user_clk(clk), .user_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_length(cmd_length), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
    .rsp_read_data(rsp_read_data), .rsp_tag(rsp_tag), .rsp_status(rsp_status),
    .rsp_timestamp(rsp_timestamp),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata),
    .soft_rst(soft_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference cycle counter and bus-access counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end

  always @(posedge clk) begin
    req_prev <= reg_req;
    if (reg_req && !req_prev) n_req <= n_req + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] t, input logic [31:0] a, input logic [31:0] d,
                          input logic [15:0] l, input logic [7:0] g);
    int n = 0;
    while (!cmd_ready && n < 30) begin tick; n++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_type = t; cmd_address = a; cmd_data = d; cmd_length = l; cmd_tag = g;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic bus_beat(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic err, input logic [31:0] rd);
    int n = 0;
    while (!reg_req && n < 40) begin tick; n++; end
    check("req_wait", 32'(reg_req), 32'd1);
    check("reg_addr", reg_addr, a);
    check("reg_we", 32'(reg_we), 32'(we));
    if (we) check("reg_wdata", reg_wdata, wd);
    reg_ack = 1'b1; reg_err = err; reg_rdata = rd;
    tick;
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = 32'd0;
  endtask

  task automatic get_rsp(input logic [7:0] ty, input logic [31:0] rd, input logic [7:0] tg,
                         input logic [7:0] st, input int hold);
    int n = 0;
    logic [31:0] exp_ts;
    while (!rsp_valid && n < 40) begin tick; n++; end
    check("rsp_wait", 32'(rsp_valid), 32'd1);
    exp_ts = cyc;
    check("rsp_type", 32'(rsp_type), 32'(ty));
    check("rsp_data", rsp_read_data, rd);
    check("rsp_tag", 32'(rsp_tag), 32'(tg));
    check("rsp_status", 32'(rsp_status), 32'(st));
    check("rsp_ts", rsp_timestamp, exp_ts);
    for (int i = 0; i < hold; i++) begin
      tick;
      check("bp_valid_ready", {30'd0, rsp_valid, cmd_ready}, 32'd2);
      check("bp_ts", rsp_timestamp, exp_ts);
      check("bp_fields", {rsp_type, rsp_tag, rsp_status, 8'd0}, {ty, tg, st, 8'd0});
      check("bp_data", rsp_read_data, rd);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt;
    // Reset state
    repeat (2) tick;
    check("rst_outs", {27'd0, cmd_ready, rsp_valid, reg_req, soft_rst, busy}, 32'd0);
    check("rst_ts", rsp_timestamp, 32'd0);
    rst_n = 1'b1;
    tick;

    // Single write, with accept-to-request latency
    send_cmd(8'h02, 32'h10, 32'hDEADBEEF, 16'd1, 8'h05);
    check("lat_req_early", {30'd0, reg_req, busy}, 32'd1);
    tick;
    check("lat_req", 32'(reg_req), 32'd1);
    bus_beat(32'h10, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0);
    get_rsp(8'h82, 32'd0, 8'h05, 8'h00, 0);

    // Burst read wrapping the address space
    send_cmd(8'h01, 32'hFFFFFFFC, 32'd0, 16'd3, 8'h11);
    bus_beat(32'hFFFFFFFC, 1'b0, 32'd0, 1'b0, 32'hA);
    check("ack_to_rsp", 32'(rsp_valid), 32'd1);
    get_rsp(8'h81, 32'hA, 8'h11, 8'h00, 0);
    bus_beat(32'h0, 1'b0, 32'd0, 1'b0, 32'hB);
    get_rsp(8'h81, 32'hB, 8'h11, 8'h00, 0);
    bus_beat(32'h4, 1'b0, 32'd0, 1'b0, 32'hC);
    get_rsp(8'h81, 32'hC, 8'h11, 8'h00, 0);
    check("burst_idle", 32'(busy), 32'd0);

    // Timeout followed by a late ack
    base = n_req;
    send_cmd(8'h01, 32'h100, 32'd0, 16'd2, 8'h09);
    cnt = 0;
    while (!reg_req && cnt < 10) begin tick; cnt++; end
    cnt = 0;
    while (reg_req && cnt < 50) begin cnt++; tick; end
    check("to_req_cycles", 32'(cnt), 32'd8);
    get_rsp(8'h81, 32'd0, 8'h09, 8'h02, 0);
    repeat (3) tick;
    reg_ack = 1'b1; tick; reg_ack = 1'b0; tick;
    check("late_ack", {29'd0, busy, reg_req, rsp_valid}, 32'd0);
    check("to_accesses", 32'(n_req - base), 32'd1);

    // Unsupported type, over-length read
    base = n_req;
    send_cmd(8'h07, 32'h0, 32'd0, 16'd1, 8'h21);
    get_rsp(8'h87, 32'd0, 8'h21, 8'h03, 0);
    send_cmd(8'h01, 32'h0, 32'd0, 16'd65, 8'h22);
    get_rsp(8'h81, 32'd0, 8'h22, 8'h04, 0);
    check("bad_no_req", 32'(n_req - base), 32'd0);

    // Zero length reads as one beat
    send_cmd(8'h01, 32'h20, 32'd0, 16'd0, 8'h23);
    bus_beat(32'h20, 1'b0, 32'd0, 1'b0, 32'h5A5A);
    get_rsp(8'h81, 32'h5A5A, 8'h23, 8'h00, 0);
    check("len0_idle", 32'(busy), 32'd0);

    // Write burst with error on beat 2
    base = n_req;
    send_cmd(8'h02, 32'h40, 32'h0BADF00D, 16'd4, 8'h24);
    bus_beat(32'h40, 1'b1, 32'h0BADF00D, 1'b0, 32'd0);
    check("wr_gap", 32'(reg_req), 32'd0);
    bus_beat(32'h44, 1'b1, 32'h0BADF00D, 1'b1, 32'd0);
    get_rsp(8'h82, 32'd0, 8'h24, 8'h01, 0);
    repeat (3) tick;
    check("wr_err_accesses", 32'(n_req - base), 32'd2);

    // Backpressure for 10 cycles
    send_cmd(8'h01, 32'h80, 32'd0, 16'd1, 8'h25);
    bus_beat(32'h80, 1'b0, 32'd0, 1'b0, 32'h1234);
    get_rsp(8'h81, 32'h1234, 8'h25, 8'h00, 10);

    // Soft reset pulse width
    send_cmd(8'h03, 32'h0, 32'd0, 16'd1, 8'h33);
    cnt = 0;
    for (int i = 0; i < 60 && !rsp_valid; i++) begin
      if (soft_rst) cnt++;
      tick;
    end
    check("srst_width", 32'(cnt), 32'd16);
    get_rsp(8'h83, 32'd0, 8'h33, 8'h00, 0);

    // Asynchronous reset in the middle of a burst read
    send_cmd(8'h01, 32'h200, 32'd0, 16'd3, 8'h44);
    bus_beat(32'h200, 1'b0, 32'd0, 1'b0, 32'h77);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {27'd0, cmd_ready, rsp_valid, reg_req, soft_rst, busy}, 32'd0);
    check("mid_rst_fields", {rsp_type, rsp_tag, rsp_status, 8'd0}, 32'd0);
    check("mid_rst_data", rsp_read_data | rsp_timestamp | reg_addr, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rsp_valid || reg_req) cnt++;
    end
    check("post_rst_quiet", 32'(cnt), 32'd0);
    send_cmd(8'h02, 32'h30, 32'hCAFEF00D, 16'd1, 8'h55);
    bus_beat(32'h30, 1'b1, 32'hCAFEF00D, 1'b0, 32'd0);
    get_rsp(8'h82, 32'd0, 8'h55, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
